seg7_scan_controller: RTL and testbench



---
 rtl/seg7_scan_if.sv | 35 +++
 rtl/seg7_scan_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_seg7_scan_controller.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if
//   Bundles the 4-digit 7-segment scan controller's control, data and
//   display-drive signals.
//   master : the block that supplies data (drives en/load/data_in/dp_in)
//   slave  : the scan controller (drives an/seg/dp/digit_idx/frame_done)
//   en         scan enable; low = display dark
//   load       one-cycle strobe capturing data_in/dp_in
//   data_in    [15:12] = digit 0 (leftmost) ... [3:0] = digit 3
//   dp_in      bit 3 = digit 0 ... bit 0 = digit 3; 1 = lit
//   an         anode select, active low
//   seg        segments {g,f,e,d,c,b,a}, active low
//   dp         decimal point, active low
//   digit_idx  digit currently in its slot
//   frame_done one-cycle pulse at the end of each frame
interface seg7_scan_if;
  logic        en;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_done;

  modport master (
    output en, load, data_in, dp_in,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  en, load, data_in, dp_in,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller
//   Time-multiplexed scan controller for a 4-digit common-anode 7-segment
//   display. Each digit owns a PRESCALE-cycle slot: DEADTIME cycles with all
//   anodes off (anti-ghosting), then the rest of the slot driven. Loaded data
//   sits in a pending register and moves into the displayed (shadow) register
//   only at frame boundaries, so a frame never mixes old and new digits.
// Ports
//   clk  system clock
//   rst  asynchronous, active-high reset
//   bus  seg7_scan_if.slave (en, load, data_in, dp_in -> an, seg, dp,
//        digit_idx, frame_done); all outputs are registered
// Parameters
//   PRESCALE  clk cycles per digit slot (> DEADTIME + 1)
//   DEADTIME  blank cycles at the start of each slot (>= 1)
// Optional build macro
//   SEG7_LZB_EN  leading-zero blanking of digits 0..2 (digit 3 never blanked,
//                dp unaffected). Undefined: every digit shows its nibble.
module seg7_scan_controller #(
  parameter int PRESCALE = 50000,
  parameter int DEADTIME = 8
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);

  localparam int CNT_W = $clog2(PRESCALE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [15:0]      pend_data_r;
  logic [3:0]       pend_dp_r;
  logic             pend_flag_r;
  logic [15:0]      shad_data_r;
  logic [3:0]       shad_dp_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic             fd_r;

  logic             slot_end_s;
  logic             blank_end_s;
  logic             wrap_s;
  logic [3:0]       cur_nib_s;
  logic             cur_dp_s;
  logic             lz_blank_s;
  logic [6:0]       drive_seg_s;

  // Active-low hex decode, segment order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      4'hF:    s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Active-low anode select for a digit index
  function automatic logic [3:0] anode_map(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = 4'b0111;
      2'd1:    a = 4'b1011;
      2'd2:    a = 4'b1101;
      2'd3:    a = 4'b1110;
      default: a = 4'b1111;
    endcase
    return a;
  endfunction

  // Slot-counter milestones and the frame-boundary (digit 3 -> 0) cycle
  always_comb begin
    slot_end_s  = (cnt_r == CNT_W'(PRESCALE - 1));
    blank_end_s = (cnt_r == CNT_W'(DEADTIME - 1));
    wrap_s      = bus.en && (state_r == DRIVE) && slot_end_s && (idx_r == 2'd3);
  end

  // Select the shadow nibble and decimal point of the current digit
  always_comb begin
    cur_nib_s = 4'h0;
    cur_dp_s  = 1'b0;
    case (idx_r)
      2'd0: begin cur_nib_s = shad_data_r[15:12]; cur_dp_s = shad_dp_r[3]; end
      2'd1: begin cur_nib_s = shad_data_r[11:8];  cur_dp_s = shad_dp_r[2]; end
      2'd2: begin cur_nib_s = shad_data_r[7:4];   cur_dp_s = shad_dp_r[1]; end
      2'd3: begin cur_nib_s = shad_data_r[3:0];   cur_dp_s = shad_dp_r[0]; end
      default: begin cur_nib_s = 4'h0; cur_dp_s = 1'b0; end
    endcase
  end

`ifdef SEG7_LZB_EN
  logic [2:0] lz_mask_s;

  // A digit is a leading zero when it and every digit to its left are zero
  always_comb begin
    lz_mask_s[0] = (shad_data_r[15:12] == 4'h0);
    lz_mask_s[1] = lz_mask_s[0] && (shad_data_r[11:8] == 4'h0);
    lz_mask_s[2] = lz_mask_s[1] && (shad_data_r[7:4] == 4'h0);
    if (idx_r == 2'd3) begin
      lz_blank_s = 1'b0;
    end else begin
      lz_blank_s = lz_mask_s[idx_r];
    end
  end
`else
  // Blanking disabled: every digit shows its decoded nibble
  always_comb begin
    lz_blank_s = 1'b0;
  end
`endif

  // Segment pattern to present when the current digit enters DRIVE
  always_comb begin
    if (lz_blank_s) begin
      drive_seg_s = 7'h7F;
    end else begin
      drive_seg_s = hex_to_seg(cur_nib_s);
    end
  end

  // Scan FSM, double-buffered data path and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      idx_r       <= 2'd0;
      pend_data_r <= 16'h0000;
      pend_dp_r   <= 4'h0;
      pend_flag_r <= 1'b0;
      shad_data_r <= 16'h0000;
      shad_dp_r   <= 4'h0;
      an_r        <= 4'b1111;
      seg_r       <= 7'h7F;
      dp_r        <= 1'b1;
      fd_r        <= 1'b0;
    end else begin
      fd_r <= 1'b0;
      if (!bus.en) begin
        // Go dark; pending data and its flag are deliberately kept
        state_r <= IDLE;
        cnt_r   <= '0;
        idx_r   <= 2'd0;
        an_r    <= 4'b1111;
        seg_r   <= 7'h7F;
        dp_r    <= 1'b1;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= BLANK;
            cnt_r   <= '0;
            idx_r   <= 2'd0;
            if (pend_flag_r) begin
              shad_data_r <= pend_data_r;
              shad_dp_r   <= pend_dp_r;
              pend_flag_r <= 1'b0;
            end
          end
          BLANK: begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (blank_end_s) begin
              // idx and shadow are stable across BLANK, so decode them now
              state_r <= DRIVE;
              an_r    <= anode_map(idx_r);
              seg_r   <= drive_seg_s;
              dp_r    <= ~cur_dp_s;
            end
          end
          DRIVE: begin
            if (slot_end_s) begin
              state_r <= BLANK;
              cnt_r   <= '0;
              idx_r   <= idx_r + 2'd1;
              an_r    <= 4'b1111;
              seg_r   <= 7'h7F;
              dp_r    <= 1'b1;
              if (idx_r == 2'd3) begin
                fd_r <= 1'b1;
                if (pend_flag_r) begin
                  shad_data_r <= pend_data_r;
                  shad_dp_r   <= pend_dp_r;
                  pend_flag_r <= 1'b0;
                end
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 2'd0;
            an_r    <= 4'b1111;
            seg_r   <= 7'h7F;
            dp_r    <= 1'b1;
          end
        endcase
      end
      // Load comes last so it overrides the boundary copy above; a load on the
      // boundary cycle bypasses pending and lands straight in shadow.
      if (bus.load) begin
        pend_data_r <= bus.data_in;
        pend_dp_r   <= bus.dp_in;
        if (wrap_s) begin
          shad_data_r <= bus.data_in;
          shad_dp_r   <= bus.dp_in;
          pend_flag_r <= 1'b0;
        end else begin
          pend_flag_r <= 1'b1;
        end
      end
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.digit_idx  = idx_r;
  assign bus.frame_done = fd_r;

endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller
//   Directed testbench for seg7_scan_controller with PRESCALE=10, DEADTIME=2.
//   Define SEG7_LZB_EN for both files to include the leading-zero test.
module tb_seg7_scan_controller;
  localparam int PRESCALE = 10;
  localparam int DEADTIME = 2;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  // One captured frame: per digit anode/segments/dp in the first DRIVE cycle,
  // slot timing (2 dark cycles, drive held to slot end) and frame_done pulses
  logic [15:0] an_c;
  logic [27:0] seg_c;
  logic [3:0]  dp_c;
  logic [3:0]  slot_c;
  logic        fd_mid;
  logic        fd_end;

  seg7_scan_if bus_if ();

  seg7_scan_controller #(
    .PRESCALE(PRESCALE),
    .DEADTIME(DEADTIME)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] an_exp(input int d);
    case (d)
      0:       return 4'b0111;
      1:       return 4'b1011;
      2:       return 4'b1101;
      default: return 4'b1110;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [15:0] data, input logic [3:0] dps);
    bus_if.load    = 1'b1;
    bus_if.data_in = data;
    bus_if.dp_in   = dps;
    tick;
    bus_if.load    = 1'b0;
  endtask

  task automatic wait_frame(input string name);
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (bus_if.frame_done !== 1'b1 && n < 200);
    checks++;
    if (bus_if.frame_done !== 1'b1) begin
      fails++;
      $display("FAIL %s wait_frame: frame_done=%b after %0d cycles, expected 1", name, bus_if.frame_done, n);
    end
  endtask

  // Starts on the sample just after a frame boundary (digit 0, counter 0)
  task automatic capture_frame;
    slot_c = 4'h0;
    fd_mid = 1'b0;
    for (int d = 0; d < 4; d++) begin
      slot_c[d] = (bus_if.an === 4'hF);
      tick;
      slot_c[d] = slot_c[d] & (bus_if.an === 4'hF);
      fd_mid = fd_mid | bus_if.frame_done;
      tick;
      an_c[4*d +: 4] = bus_if.an;
      seg_c[7*d +: 7] = bus_if.seg;
      dp_c[d] = bus_if.dp;
      fd_mid = fd_mid | bus_if.frame_done;
      for (int k = 0; k < 8; k++) begin
        tick;
        if (k == 6) slot_c[d] = slot_c[d] & (bus_if.an === an_c[4*d +: 4]) & (bus_if.an !== 4'hF);
        if (!(d == 3 && k == 7)) fd_mid = fd_mid | bus_if.frame_done;
      end
    end
    fd_end = bus_if.frame_done;
  endtask

  task automatic test_reset;
    bus_if.en = 1'b0; bus_if.load = 1'b0; bus_if.data_in = 16'h0000; bus_if.dp_in = 4'h0;
    rst = 1'b1;
    #3;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL reset an: got %b expected 1111", bus_if.an); end
    checks++; if (bus_if.seg !== 7'h7F) begin fails++; $display("FAIL reset seg: got %h expected 7f", bus_if.seg); end
    checks++; if (bus_if.dp !== 1'b1) begin fails++; $display("FAIL reset dp: got %b expected 1", bus_if.dp); end
    checks++; if (bus_if.digit_idx !== 2'd0) begin fails++; $display("FAIL reset digit_idx: got %0d expected 0", bus_if.digit_idx); end
    checks++; if (bus_if.frame_done !== 1'b0) begin fails++; $display("FAIL reset frame_done: got %b expected 0", bus_if.frame_done); end
    tick; tick;
    rst = 1'b0;
    tick; tick; tick;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL idle_dark an: got %b expected 1111", bus_if.an); end
  endtask

  task automatic test_display;
    logic [27:0] exp_seg;
    bus_if.en = 1'b1;
    pulse_load(16'h1234, 4'h0);
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL start_blank0 an: got %b expected 1111", bus_if.an); end
    tick;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL start_blank1 an: got %b expected 1111", bus_if.an); end
    tick;
    checks++; if (bus_if.an !== 4'b0111) begin fails++; $display("FAIL start_drive an: got %b expected 0111", bus_if.an); end
    wait_frame("display");
    capture_frame;
    exp_seg = {7'h19, 7'h30, 7'h24, 7'h79};
    for (int d = 0; d < 4; d++) begin
      checks++; if (slot_c[d] !== 1'b1) begin fails++; $display("FAIL display slot%0d timing: got 0 expected 1", d); end
      checks++; if (an_c[4*d +: 4] !== an_exp(d)) begin fails++; $display("FAIL display an%0d: got %b expected %b", d, an_c[4*d +: 4], an_exp(d)); end
      checks++; if (seg_c[7*d +: 7] !== exp_seg[7*d +: 7]) begin fails++; $display("FAIL display seg%0d: got %h expected %h", d, seg_c[7*d +: 7], exp_seg[7*d +: 7]); end
      checks++; if (dp_c[d] !== 1'b1) begin fails++; $display("FAIL display dp%0d: got %b expected 1", d, dp_c[d]); end
    end
    checks++; if ({fd_mid, fd_end} !== 2'b01) begin fails++; $display("FAIL display frame_done mid/end: got %b expected 01", {fd_mid, fd_end}); end
  endtask

  task automatic test_mid_frame_load;
    logic [27:0] exp_seg;
    logic [3:0]  exp_dp;
    tick; tick;
    pulse_load(16'hABCD, 4'b0101);
    repeat (9) tick;
    checks++; if (bus_if.an !== 4'b1011) begin fails++; $display("FAIL midload old_an: got %b expected 1011", bus_if.an); end
    checks++; if (bus_if.seg !== 7'h24) begin fails++; $display("FAIL midload old_seg: got %h expected 24", bus_if.seg); end
    checks++; if (bus_if.dp !== 1'b1) begin fails++; $display("FAIL midload old_dp: got %b expected 1", bus_if.dp); end
    wait_frame("midload");
    capture_frame;
    exp_seg = {7'h21, 7'h46, 7'h03, 7'h08};
    exp_dp  = 4'b0101;
    for (int d = 0; d < 4; d++) begin
      checks++; if (slot_c[d] !== 1'b1) begin fails++; $display("FAIL midload slot%0d timing: got 0 expected 1", d); end
      checks++; if (an_c[4*d +: 4] !== an_exp(d)) begin fails++; $display("FAIL midload an%0d: got %b expected %b", d, an_c[4*d +: 4], an_exp(d)); end
      checks++; if (seg_c[7*d +: 7] !== exp_seg[7*d +: 7]) begin fails++; $display("FAIL midload seg%0d: got %h expected %h", d, seg_c[7*d +: 7], exp_seg[7*d +: 7]); end
      checks++; if (dp_c[d] !== exp_dp[d]) begin fails++; $display("FAIL midload dp%0d: got %b expected %b", d, dp_c[d], exp_dp[d]); end
    end
    checks++; if ({fd_mid, fd_end} !== 2'b01) begin fails++; $display("FAIL midload frame_done mid/end: got %b expected 01", {fd_mid, fd_end}); end
  endtask

  task automatic test_boundary_load;
    logic [27:0] exp_seg;
    repeat (39) tick;
    pulse_load(16'hF00F, 4'h0);
    checks++; if (bus_if.frame_done !== 1'b1) begin fails++; $display("FAIL boundary frame_done: got %b expected 1", bus_if.frame_done); end
    capture_frame;
    exp_seg = {7'h0E, 7'h40, 7'h40, 7'h0E};
    for (int d = 0; d < 4; d++) begin
      checks++; if (an_c[4*d +: 4] !== an_exp(d)) begin fails++; $display("FAIL boundary an%0d: got %b expected %b", d, an_c[4*d +: 4], an_exp(d)); end
      checks++; if (seg_c[7*d +: 7] !== exp_seg[7*d +: 7]) begin fails++; $display("FAIL boundary seg%0d: got %h expected %h", d, seg_c[7*d +: 7], exp_seg[7*d +: 7]); end
      checks++; if (dp_c[d] !== 1'b1) begin fails++; $display("FAIL boundary dp%0d: got %b expected 1", d, dp_c[d]); end
    end
    checks++; if ({fd_mid, fd_end} !== 2'b01) begin fails++; $display("FAIL boundary frame_done mid/end: got %b expected 01", {fd_mid, fd_end}); end
  endtask

  task automatic test_back_to_back;
    tick; tick; tick;
    pulse_load(16'h1111, 4'h0);
    pulse_load(16'h2222, 4'h0);
    wait_frame("b2b");
    capture_frame;
    for (int d = 0; d < 4; d++) begin
      checks++; if (an_c[4*d +: 4] !== an_exp(d)) begin fails++; $display("FAIL b2b an%0d: got %b expected %b", d, an_c[4*d +: 4], an_exp(d)); end
      checks++; if (seg_c[7*d +: 7] !== 7'h24) begin fails++; $display("FAIL b2b seg%0d: got %h expected 24", d, seg_c[7*d +: 7]); end
    end
  endtask

  task automatic test_en_drop;
    int fd_seen;
    int lit_seen;
    repeat (22) tick;
    checks++; if (bus_if.an !== 4'b1101) begin fails++; $display("FAIL endrop pre_an: got %b expected 1101", bus_if.an); end
    bus_if.en = 1'b0;
    tick;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL endrop an: got %b expected 1111", bus_if.an); end
    checks++; if (bus_if.seg !== 7'h7F) begin fails++; $display("FAIL endrop seg: got %h expected 7f", bus_if.seg); end
    checks++; if (bus_if.digit_idx !== 2'd0) begin fails++; $display("FAIL endrop digit_idx: got %0d expected 0", bus_if.digit_idx); end
    checks++; if (bus_if.frame_done !== 1'b0) begin fails++; $display("FAIL endrop frame_done: got %b expected 0", bus_if.frame_done); end
    fd_seen = 0;
    lit_seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick;
      if (bus_if.frame_done !== 1'b0) fd_seen++;
      if (bus_if.an !== 4'b1111) lit_seen++;
    end
    checks++; if (fd_seen != 0) begin fails++; $display("FAIL idle frame_done pulses: got %0d expected 0", fd_seen); end
    checks++; if (lit_seen != 0) begin fails++; $display("FAIL idle lit cycles: got %0d expected 0", lit_seen); end
    bus_if.en = 1'b1;
    tick;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL reen blank0 an: got %b expected 1111", bus_if.an); end
    tick;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL reen blank1 an: got %b expected 1111", bus_if.an); end
    tick;
    checks++; if (bus_if.an !== 4'b0111) begin fails++; $display("FAIL reen drive an: got %b expected 0111", bus_if.an); end
    checks++; if (bus_if.seg !== 7'h24) begin fails++; $display("FAIL reen drive seg: got %h expected 24", bus_if.seg); end
  endtask

  task automatic test_async_reset;
    tick;
    checks++; if (bus_if.an !== 4'b0111) begin fails++; $display("FAIL areset pre_an: got %b expected 0111", bus_if.an); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus_if.an !== 4'b1111) begin fails++; $display("FAIL areset an: got %b expected 1111", bus_if.an); end
    checks++; if (bus_if.seg !== 7'h7F) begin fails++; $display("FAIL areset seg: got %h expected 7f", bus_if.seg); end
    checks++; if (bus_if.dp !== 1'b1) begin fails++; $display("FAIL areset dp: got %b expected 1", bus_if.dp); end
    checks++; if (bus_if.digit_idx !== 2'd0) begin fails++; $display("FAIL areset digit_idx: got %0d expected 0", bus_if.digit_idx); end
    #1;
    rst = 1'b0;
    tick;
  endtask

`ifdef SEG7_LZB_EN
  task automatic test_lzb;
    logic [15:0] vec_data [2];
    logic [3:0]  vec_dp   [2];
    logic [27:0] vec_seg  [2];
    logic [3:0]  vec_edp  [2];
    vec_data[0] = 16'h0050; vec_dp[0] = 4'b1000; vec_seg[0] = {7'h40, 7'h12, 7'h7F, 7'h7F}; vec_edp[0] = 4'b1110;
    vec_data[1] = 16'h0000; vec_dp[1] = 4'b0000; vec_seg[1] = {7'h40, 7'h7F, 7'h7F, 7'h7F}; vec_edp[1] = 4'b1111;
    for (int v = 0; v < 2; v++) begin
      pulse_load(vec_data[v], vec_dp[v]);
      wait_frame("lzb");
      capture_frame;
      for (int d = 0; d < 4; d++) begin
        checks++; if (seg_c[7*d +: 7] !== vec_seg[v][7*d +: 7]) begin fails++; $display("FAIL lzb%0d seg%0d: got %h expected %h", v, d, seg_c[7*d +: 7], vec_seg[v][7*d +: 7]); end
        checks++; if (dp_c[d] !== vec_edp[v][d]) begin fails++; $display("FAIL lzb%0d dp%0d: got %b expected %b", v, d, dp_c[d], vec_edp[v][d]); end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    fails  = 0;
    test_reset;
    test_display;
    test_mid_frame_load;
    test_boundary_load;
    test_back_to_back;
    test_en_drop;
    test_async_reset;
`ifdef SEG7_LZB_EN
    test_lzb;
`endif
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
